// File: rtl/fetch_unit.sv
// fetch_unit: owns the program counter, drives the instruction_memory address
// and registers the returned word into ir/ir_pc/ir_valid for the decoder.
// States: BOOT (post-reset idle), RUN (fetching), HOLD (stalled), HALT (frozen).
// Optional macro FETCH_PERF_EN adds a saturating fetch_count output.
module fetch_unit #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 15,
  parameter int RESET_PC    = 0,
  parameter int BOOT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt_req,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic [ADDR_W-1:0]  pc,
`ifdef FETCH_PERF_EN
  output logic [15:0]        fetch_count,
`endif
  output logic               halted
);

  // Three-bit encoding leaves spare codes; any of them falls back to BOOT.
  typedef enum logic [2:0] {
    BOOT = 3'd0,
    RUN  = 3'd1,
    HOLD = 3'd2,
    HALT = 3'd3
  } state_t;

  localparam logic [3:0]        BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);

  state_t              state, state_n;
  logic [3:0]          boot_cnt, boot_cnt_n;
  logic [ADDR_W-1:0]   pc_n, ir_pc_n;
  logic [INSTR_W-1:0]  ir_n;
  logic                ir_valid_n;
  logic                do_fetch;

  assign im_addr = pc;
  assign halted  = (state == HALT);

  // Next-state and datapath decode; halt beats jump, jump beats stall.
  always_comb begin
    state_n    = state;
    boot_cnt_n = boot_cnt;
    pc_n       = pc;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    do_fetch   = 1'b0;

    case (state)
      BOOT: begin
        ir_valid_n = 1'b0;
        boot_cnt_n = boot_cnt + 4'd1;
        if (boot_cnt == BOOT_LAST) begin
          state_n = RUN;
        end
      end
      RUN, HOLD: begin
        if (halt_req) begin
          state_n    = HALT;
          ir_valid_n = 1'b0;
        end else if (jump_en) begin
          state_n    = RUN;
          pc_n       = jump_addr;
          ir_valid_n = 1'b0;
        end else if (stall) begin
          state_n = HOLD;
        end else begin
          state_n  = RUN;
          do_fetch = 1'b1;
        end
      end
      HALT: begin
        ir_valid_n = 1'b0;
      end
      default: begin
        state_n    = BOOT;
        boot_cnt_n = 4'd0;
        ir_valid_n = 1'b0;
      end
    endcase

    if (do_fetch) begin
      ir_n       = im_data;
      ir_pc_n    = pc;
      ir_valid_n = 1'b1;
      pc_n       = pc + ADDR_W'(1);
    end
  end

  // State and fetch registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      boot_cnt <= 4'd0;
      pc       <= PC_INIT;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_n;
      boot_cnt <= boot_cnt_n;
      pc       <= pc_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= ir_valid_n;
    end
  end

`ifdef FETCH_PERF_EN
  // Counts successful sequential fetches only, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= 16'd0;
    end else if (do_fetch && (fetch_count != 16'hFFFF)) begin
      fetch_count <= fetch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit. Stimulus pushes the
// expected ir/ir_pc for every cycle ir_valid should be high; a negedge monitor
// pops and compares whenever the DUT shows ir_valid.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        halt_req;
  logic [7:0]  im_addr;
  logic [14:0] im_data;
  logic [14:0] ir;
  logic        ir_valid;
  logic [7:0]  ir_pc;
  logic [7:0]  pc;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  int          exp_fc;
`endif

  typedef struct packed {
    logic [14:0] ir;
    logic [7:0]  pc;
  } item_t;

  item_t       exp_q[$];
  item_t       last_item;
  logic [14:0] mem [256];
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_pc;

  always #5 clk = ~clk;

  // Combinational instruction memory model.
  assign im_data = mem[im_addr];

  fetch_unit #(
    .ADDR_W(8), .INSTR_W(15), .RESET_PC(0), .BOOT_CYCLES(1)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .jump_en(jump_en),
    .jump_addr(jump_addr), .halt_req(halt_req), .im_addr(im_addr),
    .im_data(im_data), .ir(ir), .ir_valid(ir_valid), .ir_pc(ir_pc),
    .pc(pc),
`ifdef FETCH_PERF_EN
    .fetch_count(fetch_count),
`endif
    .halted(halted)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic j, input logic [7:0] ja,
                               input logic h);
    stall     = s;
    jump_en   = j;
    jump_addr = ja;
    halt_req  = h;
    @(posedge clk);
    #1;
  endtask

  // A normal fetch at exp_pc: expect mem[exp_pc] on ir next edge.
  task automatic doFetch();
    last_item = '{ir: mem[exp_pc], pc: exp_pc};
    exp_q.push_back(last_item);
`ifdef FETCH_PERF_EN
    if (exp_fc < 65535) exp_fc++;
`endif
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
    exp_pc = exp_pc + 8'd1;
  endtask

  // A stall cycle: ir_valid stays high with the same word.
  task automatic doStall();
    exp_q.push_back(last_item);
    applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
  endtask

  // Monitor: compare each presented valid instruction against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && ir_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_valid: got ir_pc %0d expected no valid word", ir_pc);
      end else begin
        item_t e;
        e = exp_q.pop_front();
        checkOutput("mon_ir", int'(ir), int'(e.ir));
        checkOutput("mon_ir_pc", int'(ir_pc), int'(e.pc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 15'((i * 37 + 5) & 16'h7FFF);
    mem[0] = 15'b000001000001111;
    mem[1] = 15'b000001100000000;
`ifdef FETCH_PERF_EN
    exp_fc = 0;
`endif
    rst = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = 8'd0; halt_req = 1'b0;

    // Reset for two edges.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_ir_valid", int'(ir_valid), 0);
      checkOutput("rst_pc", int'(pc), 0);
      checkOutput("rst_halted", int'(halted), 0);
    end
    rst = 1'b0;
    exp_pc = 8'd0;

    // Boot cycle: nothing fetched yet.
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
    checkOutput("boot_ir_valid", int'(ir_valid), 0);
    checkOutput("boot_pc", int'(pc), 0);

    // First fetch from address 0.
    doFetch();
    checkOutput("first_ir", int'(ir), 15'b000001000001111);
    checkOutput("first_ir_pc", int'(ir_pc), 0);
    checkOutput("first_pc", int'(pc), 1);
`ifdef FETCH_PERF_EN
    checkOutput("first_fetch_count", int'(fetch_count), 1);
`endif

    // Five sequential fetches: ir_pc 1..5, pc ends at 6.
    for (int i = 1; i <= 5; i++) begin
      doFetch();
      checkOutput("seq_pc", int'(pc), i + 1);
      checkOutput("seq_ir_valid", int'(ir_valid), 1);
    end

    // Jump to 1 at pc=6: one bubble then target word.
    applyStimulus(1'b0, 1'b1, 8'd1, 1'b0);
    exp_pc = 8'd1;
    checkOutput("jump_pc", int'(pc), 1);
    checkOutput("jump_ir_valid", int'(ir_valid), 0);
    doFetch();
    checkOutput("jump_tgt_ir", int'(ir), 15'b000001100000000);
    checkOutput("jump_tgt_ir_pc", int'(ir_pc), 1);

    // Jump with simultaneous stall: jump wins.
    applyStimulus(1'b1, 1'b1, 8'd1, 1'b0);
    exp_pc = 8'd1;
    checkOutput("jstall_pc", int'(pc), 1);
    checkOutput("jstall_ir_valid", int'(ir_valid), 0);
    doFetch();
    checkOutput("jstall_tgt_ir", int'(ir), 15'b000001100000000);
    checkOutput("jstall_pc2", int'(pc), 2);

    // Advance to pc=3, then stall three cycles and release.
    doFetch();
    checkOutput("pre_stall_pc", int'(pc), 3);
    for (int i = 0; i < 3; i++) begin
      doStall();
      checkOutput("stall_pc", int'(pc), 3);
      checkOutput("stall_ir_pc", int'(ir_pc), 2);
      checkOutput("stall_ir_valid", int'(ir_valid), 1);
    end
    doFetch();
    checkOutput("release_ir_pc", int'(ir_pc), 3);
    checkOutput("release_pc", int'(pc), 4);

    // Wrap: jump to 254 and run across the top of the address space.
    applyStimulus(1'b0, 1'b1, 8'd254, 1'b0);
    exp_pc = 8'd254;
    checkOutput("wrap_jump_pc", int'(pc), 254);
    doFetch(); checkOutput("wrap_pc_a", int'(pc), 255);
    doFetch(); checkOutput("wrap_pc_b", int'(pc), 0);
    doFetch(); checkOutput("wrap_pc_c", int'(pc), 1);
    checkOutput("wrap_ir_pc", int'(ir_pc), 0);

    // Get to pc=4, then halt with a simultaneous jump.
    applyStimulus(1'b0, 1'b1, 8'd4, 1'b0);
    checkOutput("prehalt_pc", int'(pc), 4);
    applyStimulus(1'b0, 1'b1, 8'd9, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("halt_halted", int'(halted), 1);
      checkOutput("halt_pc", int'(pc), 4);
      checkOutput("halt_ir_valid", int'(ir_valid), 0);
      checkOutput("halt_ir_pc", int'(ir_pc), 0);
      applyStimulus(1'($urandom_range(0, 1)), 1'b1, 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
    end
    checkOutput("halt_end_pc", int'(pc), 4);

    // Reset leaves HALT.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
    checkOutput("rerst_pc", int'(pc), 0);
    checkOutput("rerst_halted", int'(halted), 0);
    checkOutput("rerst_ir", int'(ir), 0);
    checkOutput("rerst_ir_valid", int'(ir_valid), 0);
`ifdef FETCH_PERF_EN
    exp_fc = 0;
    checkOutput("rerst_fetch_count", int'(fetch_count), 0);
`endif
    rst = 1'b0;
    exp_pc = 8'd0;
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
    checkOutput("reboot_ir_valid", int'(ir_valid), 0);
    doFetch();
    checkOutput("reboot_ir", int'(ir), 15'b000001000001111);
    checkOutput("reboot_pc", int'(pc), 1);
`ifdef FETCH_PERF_EN
    checkOutput("reboot_fetch_count", int'(fetch_count), exp_fc);
`endif

    @(negedge clk); #1;
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
